// File: rtl/event_blinker.sv
// event_blinker: turns single-cycle event strobes into visible LED blinks.
// Each event yields one blink (ON_CYCLES lit, OFF_CYCLES dark). Events that
// arrive mid-blink are counted in a saturating pending counter and replayed
// back to back.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-low reset
//   event_in - event strobe, one event per high cycle
//   led_out  - registered LED drive (1 = lit)
//   busy     - registered, high while a blink is in progress
//   pending  - registered count of queued events not yet started
//   overflow - registered one-cycle pulse when an event is dropped
module event_blinker #(
    parameter int ON_CYCLES  = 10000,
    parameter int OFF_CYCLES = 10000,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              event_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);
    localparam int MAX_C = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW = $clog2(MAX_C + 1);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              led_q, busy_q, ovf_q, ovf_d;
    logic              last_on, last_off;

    assign last_on  = (state_q == S_ON)  && (timer_q == ON_LAST);
    assign last_off = (state_q == S_OFF) && (timer_q == OFF_LAST);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        ovf_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (event_in) begin
                    state_d = S_ON;
                    timer_d = '0;
                end
            end
            S_ON: begin
                state_d = last_on ? S_OFF : S_ON;
                timer_d = last_on ? '0 : timer_q + 1'b1;
            end
            S_OFF: begin
                if (last_off) begin
                    timer_d = '0;
                    if (pend_q != '0) begin
                        // a simultaneous event replaces the one dequeued, so no net change
                        state_d = S_ON;
                        pend_d  = event_in ? pend_q : pend_q - 1'b1;
                    end else begin
                        state_d = event_in ? S_ON : S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
        // events during a blink are queued, except the final OFF cycle handled above
        if (event_in && state_q != S_IDLE && !last_off) begin
            if (&pend_q) ovf_d = 1'b1;
            else         pend_d = pend_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            led_q   <= (state_d == S_ON);
            busy_q  <= (state_d != S_IDLE);
            ovf_q   <= ovf_d;
        end
    end

    assign led_out  = led_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;
endmodule
